// File: rtl/baugh_wooley_pkg.sv
// Shared types and constants for the iterative Baugh-Wooley multiplier.
// Supports operand widths up to 64 bits through bw_correction.
package baugh_wooley_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } bw_state_e;

    // Returns 2^w + 2^(2w-1); callers truncate to 2w bits.
    function automatic logic [127:0] bw_correction(input int unsigned w);
        logic [127:0] r;
        r = '0;
        r[w] = 1'b1;
        r[2*w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/baugh_wooley_pp_row.sv
// One unshifted partial-product row, with the Baugh-Wooley inversions in signed mode.
module baugh_wooley_pp_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic             y_bit_i,
    input  logic             is_signed_i,
    input  logic             is_last_row_i,
    output logic [WIDTH-1:0] row_o
);

    logic [WIDTH-1:0] and_bits;

    always_comb begin
        and_bits = x_i & {WIDTH{y_bit_i}};
        row_o    = and_bits;
        if (is_signed_i) begin
            if (is_last_row_i) begin
                row_o[WIDTH-2:0] = ~and_bits[WIDTH-2:0];
            end else begin
                row_o[WIDTH-1] = ~and_bits[WIDTH-1];
            end
        end
    end

endmodule

// File: rtl/baugh_wooley_multiplier_iter.sv
// Sequential WIDTH x WIDTH multiplier adding one partial-product row per clock,
// with valid/ready handshakes on operands and product.
module baugh_wooley_multiplier_iter
    import baugh_wooley_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [ACC_W-1:0] CORR = ACC_W'(bw_correction(WIDTH));
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

    bw_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             signed_q;
    logic [ACC_W-1:0] z_q;

    logic             last_row;
    logic [WIDTH-1:0] row;
    logic [ACC_W-1:0] row_ext;

    assign last_row = (cnt_q == LAST_ROW);

    baugh_wooley_pp_row #(
        .WIDTH(WIDTH)
    ) u_pp_row (
        .x_i          (x_q),
        .y_bit_i      (y_q[cnt_q]),
        .is_signed_i  (signed_q),
        .is_last_row_i(last_row),
        .row_o        (row)
    );

    always_comb begin
        row_ext = {{WIDTH{1'b0}}, row} << cnt_q;
        acc_d   = acc_q + row_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
            z_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= x;
                        y_q      <= y;
                        signed_q <= is_signed;
                        cnt_q    <= '0;
                        acc_q    <= is_signed ? CORR : '0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_row) begin
                        z_q     <= acc_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = z_q;

endmodule

// File: tb/tb_baugh_wooley_multiplier_iter.sv
// Directed and swept checks of the iterative Baugh-Wooley multiplier at WIDTH=4 and WIDTH=8.
module tb_baugh_wooley_multiplier_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv4, iv8, sgn, ordy;
    logic [3:0]  x4, y4;
    logic [7:0]  x8, y8;
    logic        r4, r8, ov4, ov8;
    logic [7:0]  z4;
    logic [15:0] z8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last4 = -1;
    int last8 = -1;
    int viol4 = 0;
    int viol8 = 0;

    always #5 clk = ~clk;

    baugh_wooley_multiplier_iter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(r4), .x(x4), .y(y4),
        .is_signed(sgn), .out_valid(ov4), .out_ready(ordy), .z(z4)
    );

    baugh_wooley_multiplier_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(r8), .x(x8), .y(y8),
        .is_signed(sgn), .out_valid(ov8), .out_ready(ordy), .z(z8)
    );

    // Acceptances are observed at negedge, i.e. the values the next posedge samples.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last4 = -1;
            last8 = -1;
        end else begin
            if (iv4 && r4) begin
                if (last4 >= 0 && cyc - last4 < 6) viol4++;
                last4 = cyc;
            end
            if (iv8 && r8) begin
                if (last8 >= 0 && cyc - last8 < 10) viol8++;
                last8 = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] golden(input bit w8, input logic [7:0] a,
                                           input logic [7:0] b, input bit s);
        logic [3:0]         a4, b4;
        logic signed [7:0]  p4s;
        logic signed [15:0] p8s;
        logic [7:0]         p4u;
        logic [15:0]        p8u;
        a4  = a[3:0];
        b4  = b[3:0];
        p4s = $signed(a4) * $signed(b4);
        p8s = $signed(a) * $signed(b);
        p4u = a4 * b4;
        p8u = a * b;
        if (w8) return s ? p8s : p8u;
        return s ? {8'h00, p4s} : {8'h00, p4u};
    endfunction

    task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit s,
                      input logic [15:0] exp, input string tag, input int gap);
        int n;
        for (int i = 0; i < gap; i++) tick();
        sgn = s;
        if (w8) begin x8 = a; y8 = b; iv8 = 1'b1; end
        else    begin x4 = a[3:0]; y4 = b[3:0]; iv4 = 1'b1; end
        n = 0;
        while (!(w8 ? r8 : r4) && n < 50) begin tick(); n++; end
        if (n == 50) begin
            chk({tag, "_ready_timeout"}, 0, 1);
            iv4 = 1'b0; iv8 = 1'b0;
            return;
        end
        tick();
        iv4 = 1'b0; iv8 = 1'b0;
        x4 = ~x4; y4 = y4 + 4'd3; x8 = ~x8; y8 = y8 + 8'd7; sgn = ~sgn;
        n = 0;
        while (!(w8 ? ov8 : ov4) && n < 50) begin tick(); n++; end
        chk({tag, "_latency"}, n, w8 ? 8 : 4);
        chk({tag, "_z"}, w8 ? z8 : {8'h00, z4}, exp);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk({tag, "_ov_drop"}, w8 ? ov8 : ov4, 0);
    endtask

    initial begin
        logic [15:0] zhold;
        logic [7:0]  ra, rb;
        bit          rs;
        int          n;

        rst = 1'b1; iv4 = 1'b0; iv8 = 1'b0; sgn = 1'b0; ordy = 1'b0;
        x4 = '0; y4 = '0; x8 = '0; y8 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy4", r4, 1);
        chk("rst_ov4", ov4, 0);
        chk("rst_z4", z4, 0);
        chk("rst_rdy8", r8, 1);
        chk("rst_z8", z8, 0);

        op(0, 8'h0F, 8'h01, 1, 16'h00FF, "w4_s_F_1", 1);
        op(0, 8'h08, 8'h08, 1, 16'h0040, "w4_s_8_8", 0);
        op(0, 8'h08, 8'h08, 0, 16'h0040, "w4_u_8_8", 2);
        op(0, 8'h0F, 8'h0F, 0, 16'h00E1, "w4_u_F_F", 0);
        op(0, 8'h07, 8'h08, 1, 16'h00C8, "w4_s_7_8", 1);
        op(1, 8'h80, 8'h80, 1, 16'h4000, "w8_s_80_80", 0);
        op(1, 8'hFF, 8'hFF, 0, 16'hFE01, "w8_u_FF_FF", 1);
        op(1, 8'hFF, 8'h7F, 1, 16'hFF81, "w8_s_FF_7F", 0);
        op(1, 8'h80, 8'h7F, 1, 16'hC080, "w8_s_80_7F", 3);
        op(1, 8'h00, 8'hC3, 0, 16'h0000, "w8_u_00_C3", 0);

        // Backpressure on the 8-bit instance while in_valid and x keep moving.
        chk("bp_rdy_idle", r8, 1);
        x8 = 8'd12; y8 = 8'd10; sgn = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin tick(); n++; end
        chk("bp_latency", n, 8);
        chk("bp_z", z8, 16'd120);
        zhold = z8;
        for (int i = 0; i < 5; i++) begin
            iv8 = i[0];
            x8 = 8'($urandom);
            tick();
            chk("bp_ov_hold", ov8, 1);
            chk("bp_rdy_low", r8, 0);
            chk("bp_z_hold", z8, zhold);
        end
        x8 = 8'd3; y8 = 8'd5; sgn = 1'b1; iv8 = 1'b1; ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("bp_release_ov", ov8, 0);
        chk("bp_no_same_cycle_accept", r8, 1);
        tick();
        iv8 = 1'b0;
        chk("bp_accept_next", r8, 0);
        n = 0;
        while (!ov8 && n < 50) begin tick(); n++; end
        chk("bp_next_latency", n, 8);
        chk("bp_next_z", z8, 16'd15);
        ordy = 1'b1; tick(); ordy = 1'b0;

        // Reset during the second CALC cycle of a 4-bit operation.
        x4 = 4'h7; y4 = 4'h3; sgn = 1'b1; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_rdy", r4, 1);
        chk("abort_ov", ov4, 0);
        chk("abort_z", z4, 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov4) n++;
        end
        chk("abort_no_ov", n, 0);
        op(0, 8'h07, 8'h0D, 1, 16'h00EB, "after_abort", 0);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op(0, ra, rb, rs, golden(0, ra, rb, rs), "sweep4", $urandom_range(0, 3));
        end
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op(1, ra, rb, rs, golden(1, ra, rb, rs), "sweep8", $urandom_range(0, 3));
        end

        chk("issue_gap4", viol4, 0);
        chk("issue_gap8", viol8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
